mcu_burst_interface: RTL
========================

MCU_BURST_INTERFACE -- requirements
Module: mcu_burst_interface

Parameters
REQ-001 X_WIDTH, default 9, pixel X coordinate width; legal range 9..12.
REQ-002 Y_WIDTH, default 8, pixel Y coordinate width; legal range 1..8.
REQ-003 FIFO_DEPTH, default 4, pixel write queue entries; power of two, at least 2.
REQ-004 SYNC_STAGES, default 2, synchroniser flops on MCU bus inputs; at least 2.

Interface
REQ-005 clock  input  1  system clock; all state on posedge.
REQ-006 resetN  input  1  asynchronous, active-low reset.
REQ-007 memoryXCoord  output  X_WIDTH  X coordinate of the queued pixel write.
REQ-008 memoryYCoord  output  Y_WIDTH  Y coordinate of the queued pixel write.
REQ-009 memoryWriteData  output  8  colour of the queued pixel write.
REQ-010 memoryWriteRequest  output  1  level request to the memory manager.
REQ-011 memoryWriteComplete  input  1  memory manager acknowledge.
REQ-012 mpuChipSelect  input  1  active-high chip select; asynchronous to clock.
REQ-013 mpuWriteEnable  input  1  active-low write enable; asynchronous.
REQ-014 mpuRegisterSelect  input  3  register address.
REQ-015 mpuDataBus  inout  8  MCU data; driven only during a status read.

Function
REQ-016 Write strobe SHALL be mpuChipSelect && !mpuWriteEnable.
- The strobe, mpuRegisterSelect and mpuDataBus pass through SYNC_STAGES flops.
- A register write SHALL commit on the cycle the synchronised strobe falls (1->0).
- The commit SHALL use the address and data synchronised on the previous cycle.
REQ-017 Register map:
- 0 X_LOW: x[7:0].
- 1 X_HIGH: x[X_WIDTH-1:8] from data low bits.
- 2 Y: y from data[Y_WIDTH-1:0].
- 3 DATA: push a pixel.
- 4 BOX_START_LOW: boxStart[7:0].
- 5 BOX_STOP_LOW: boxStop[7:0].
- 6 BOX_HIGH: boxStart high bits from [3:0], boxStop high bits from [7:4].
- 7 CONTROL (write only): bit0 autoIncrement; bit1 = 1 clears overflow; bit2 = 1 flushes the FIFO.
REQ-018 A DATA commit SHALL push {x, y, data} into the FIFO if it is not full.
- If the FIFO is full the push is dropped and the sticky overflow flag sets.
- A full FIFO with a pop in the same cycle SHALL accept the push.
REQ-019 Cursor advance on each DATA commit, dropped or not, when autoIncrement = 1:
- If x == boxStop: x <= boxStart and y <= y + 1, wrapping modulo 2^Y_WIDTH.
- Otherwise x <= x + 1, wrapping modulo 2^X_WIDTH.
- When autoIncrement = 0 the cursor is unchanged.
REQ-020 A commit to X_LOW, X_HIGH or Y in the same cycle as no DATA commit SHALL write only the addressed field. Commits are one per strobe, so they never coincide.
REQ-021 Drain FSM states:
- IDLE -> REQ when the FIFO is non-empty; the head is loaded into memoryX/Y/WriteData and memoryWriteRequest is set to 1.
- REQ holds request and outputs stable until memoryWriteComplete is sampled 1, then pops and goes to GAP with request 0.
- GAP -> IDLE after one cycle.
- Request SHALL be low for at least one cycle between entries.
REQ-022 Latency SHALL be at most SYNC_STAGES+3 clocks from strobe deassertion to memoryWriteRequest = 1, when the FIFO was empty and the FSM was IDLE.
REQ-023 Flush SHALL empty the FIFO without disturbing an in-flight REQ. The in-flight entry completes normally.
REQ-024 Status read: when mpuChipSelect && mpuWriteEnable && mpuRegisterSelect == 7, mpuDataBus SHALL be driven combinationally with:
- bit0 fifoEmpty
- bit1 fifoFull
- bit2 overflow
- bit3 memoryWriteRequest
- bit4 autoIncrement
- bits 7:5 zero
REQ-025 At all other times mpuDataBus SHALL be high-impedance.

Reset
REQ-026 While resetN = 0, all of the following SHALL be 0:
- memoryWriteRequest, memoryXCoord, memoryYCoord, memoryWriteData
- x, y, boxStart, autoIncrement, overflow
- synchronisers and FIFO pointers
REQ-027 While resetN = 0, boxStop SHALL be 2^X_WIDTH-1 and the FSM SHALL be in IDLE.
REQ-028 Reset mid-REQ SHALL drop the request immediately and discard all queued entries.
REQ-029 After release, the first commit SHALL occur only on a strobe fall fully observed after release.

Verification
REQ-030 Write X_LOW=0x2A, X_HIGH=0x01, Y=0x10, DATA=0x55, then ack one cycle after request -> a single request with X=298, Y=16, data=0x55, and cursor unchanged.
REQ-031 Set CONTROL=0x01, boxStart=10, boxStop=12, x=11, y=255, then write DATA 1,2,3 -> writes at (11,255), (12,255), (10,0). Cursor ends at x=11, y=0.
REQ-032 Hold memoryWriteComplete = 0 and write 5 DATA bytes with FIFO_DEPTH=4:
- Status reads full=1, overflow=1.
- After acks, exactly 4 writes emerge in order and the 5th is lost.
- A CONTROL bit1 write clears overflow.
REQ-033 Pulse resetN low while in REQ with 3 entries queued -> request falls asynchronously; status reads 0x01 after release; no further writes occur.
REQ-034 Read status with CS=1, WE=1, select=3 -> bus stays high-Z. With select=7 on an idle block -> bus reads 0x01.

Source files
------------

// File: rtl/mcu_burst_interface_if.sv
// rtl/mcu_burst_interface_if.sv - pixel write channel between the MCU burst block and the memory manager
interface mcu_burst_interface_if #(
    parameter int X_WIDTH = 9,
    parameter int Y_WIDTH = 8
);
    logic [X_WIDTH-1:0] memoryXCoord;
    logic [Y_WIDTH-1:0] memoryYCoord;
    logic [7:0]         memoryWriteData;
    logic               memoryWriteRequest;
    logic               memoryWriteComplete;

    modport master (
        output memoryXCoord,
        output memoryYCoord,
        output memoryWriteData,
        output memoryWriteRequest,
        input  memoryWriteComplete
    );

    modport slave (
        input  memoryXCoord,
        input  memoryYCoord,
        input  memoryWriteData,
        input  memoryWriteRequest,
        output memoryWriteComplete
    );
endinterface

// File: rtl/mcu_burst_interface.sv
// rtl/mcu_burst_interface.sv - MCU register port feeding a pixel write queue drained to the memory manager
module mcu_burst_interface #(
    parameter int X_WIDTH     = 9,
    parameter int Y_WIDTH     = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  resetN,
    mcu_burst_interface_if.master mem_if,
    input  logic                  mpuChipSelect,
    input  logic                  mpuWriteEnable,
    input  logic [2:0]            mpuRegisterSelect,
    inout  wire  [7:0]            mpuDataBus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int XH = X_WIDTH - 8;
    localparam int EW = X_WIDTH + Y_WIDTH + 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

    // Bit 11 strobe, bits 10:8 register select, bits 7:0 data
    logic [SYNC_STAGES-1:0][11:0] sync_q, sync_d;
    logic [11:0] prev_q, prev_d;
    logic [11:0] sync_out;

    logic [X_WIDTH-1:0] x_q, x_d, box_start_q, box_start_d, box_stop_q, box_stop_d;
    logic [Y_WIDTH-1:0] y_q, y_d;
    logic               auto_inc_q, auto_inc_d, overflow_q, overflow_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]      fifo_mem [FIFO_DEPTH];
    logic [EW-1:0]      head;

    state_t             state_q;
    logic [X_WIDTH-1:0] mem_x_q;
    logic [Y_WIDTH-1:0] mem_y_q;
    logic [7:0]         mem_d_q;
    logic               mem_req_q;

    logic       commit, data_commit, flush, pop, push, fifo_empty, fifo_full;
    logic [2:0] c_addr;
    logic [7:0] c_data;
    logic       status_oe;
    logic [7:0] status;

    assign sync_out    = sync_q[SYNC_STAGES-1];
    assign commit      = prev_q[11] & ~sync_out[11];
    assign c_addr      = prev_q[10:8];
    assign c_data      = prev_q[7:0];
    assign data_commit = commit && (c_addr == 3'd3);
    assign flush       = commit && (c_addr == 3'd7) && c_data[2];

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = (state_q == S_REQ) && mem_if.memoryWriteComplete;
    assign push       = data_commit && (!fifo_full || pop);
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0],
                       {mpuChipSelect & ~mpuWriteEnable, mpuRegisterSelect, mpuDataBus}};
        prev_d      = sync_out;
        x_d         = x_q;
        y_d         = y_q;
        box_start_d = box_start_q;
        box_stop_d  = box_stop_q;
        auto_inc_d  = auto_inc_q;
        overflow_d  = overflow_q;
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
        wr_ptr_d    = push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
        if (commit) begin
            case (c_addr)
                3'd0: x_d[7:0] = c_data;
                3'd1: x_d[X_WIDTH-1:8] = c_data[XH-1:0];
                3'd2: y_d = c_data[Y_WIDTH-1:0];
                3'd3: begin
                    if (fifo_full && !pop) overflow_d = 1'b1;
                    if (auto_inc_q) begin
                        if (x_q == box_stop_q) begin
                            x_d = box_start_q;
                            y_d = y_q + Y_WIDTH'(1);
                        end else begin
                            x_d = x_q + X_WIDTH'(1);
                        end
                    end
                end
                3'd4: box_start_d[7:0] = c_data;
                3'd5: box_stop_d[7:0]  = c_data;
                3'd6: begin
                    box_start_d[X_WIDTH-1:8] = c_data[XH-1:0];
                    box_stop_d[X_WIDTH-1:8]  = c_data[4 +: XH];
                end
                default: begin
                    auto_inc_d = c_data[0];
                    if (c_data[1]) overflow_d = 1'b0;
                    // An unacknowledged head stays queued so its completion pop stays balanced
                    if (c_data[2]) begin
                        if (state_q == S_REQ && !pop) wr_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
                        else                          wr_ptr_d = rd_ptr_d;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sync_q      <= '0;
            prev_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            box_start_q <= '0;
            box_stop_q  <= {X_WIDTH{1'b1}};
            auto_inc_q  <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            x_q         <= x_d;
            y_q         <= y_d;
            box_start_q <= box_start_d;
            box_stop_q  <= box_stop_d;
            auto_inc_q  <= auto_inc_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {x_q, y_q, c_data};
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_IDLE;
            mem_x_q   <= '0;
            mem_y_q   <= '0;
            mem_d_q   <= '0;
            mem_req_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (!fifo_empty && !flush) begin
                    {mem_x_q, mem_y_q, mem_d_q} <= head;
                    mem_req_q <= 1'b1;
                    state_q   <= S_REQ;
                end
                S_REQ: if (mem_if.memoryWriteComplete) begin
                    mem_req_q <= 1'b0;
                    state_q   <= S_GAP;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_if.memoryXCoord       = mem_x_q;
    assign mem_if.memoryYCoord       = mem_y_q;
    assign mem_if.memoryWriteData    = mem_d_q;
    assign mem_if.memoryWriteRequest = mem_req_q;

    assign status_oe  = mpuChipSelect && mpuWriteEnable && (mpuRegisterSelect == 3'd7);
    assign status     = {3'b000, auto_inc_q, mem_req_q, overflow_q, fifo_full, fifo_empty};
    assign mpuDataBus = status_oe ? status : 8'bzzzz_zzzz;
endmodule
